battle_sequencer: RTL and testbench

//  Turn controller for the fight screen. Sequences one round as: timing-bar attack, then damage result, then heart-dodge escape.

---
 rtl/battle_sequencer_if.sv | 36 +++
 rtl/battle_sequencer.sv | 257 +++++++++++++++++++++++++
 tb/tb_battle_sequencer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/battle_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// battle_sequencer_if : key/bar/collision inputs and HP/phase/UART outputs
// Revision 1.0
// ---------------------------------------------------------------------------
interface battle_sequencer_if;
    logic        i_animate;
    logic        i_rx_receive;
    logic [7:0]  i_rx_data;
    logic [15:0] i_bar_x;
    logic        i_hit;
    logic        i_tx_idle;
    logic [2:0]  o_phase;
    logic        o_bar_run;
    logic        o_bar_reset;
    logic [15:0] o_player_hp;
    logic [15:0] o_monster_hp;
    logic [7:0]  o_last_dmg;
    logic        o_win;
    logic        o_lose;
    logic        o_tx_transmit;
    logic [7:0]  o_tx_data;

    modport master (
        output i_animate, i_rx_receive, i_rx_data, i_bar_x, i_hit, i_tx_idle,
        input  o_phase, o_bar_run, o_bar_reset, o_player_hp, o_monster_hp,
               o_last_dmg, o_win, o_lose, o_tx_transmit, o_tx_data
    );

    modport slave (
        input  i_animate, i_rx_receive, i_rx_data, i_bar_x, i_hit, i_tx_idle,
        output o_phase, o_bar_run, o_bar_reset, o_player_hp, o_monster_hp,
               o_last_dmg, o_win, o_lose, o_tx_transmit, o_tx_data
    );
endinterface
`default_nettype wire

// File: rtl/battle_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// battle_sequencer : fight-screen round controller (attack, result, dodge)
// Optional phase echo over UART: define BATTLE_TX_ECHO_EN.   Revision 1.0
// ---------------------------------------------------------------------------
module battle_sequencer #(
    parameter int unsigned CENTER_X      = 320,
    parameter int unsigned GREEN_HALF    = 10,
    parameter int unsigned YELLOW_HALF   = 100,
    parameter int unsigned ORANGE_HALF   = 160,
    parameter int unsigned BLUE_HALF     = 205,
    parameter logic [7:0]  DMG_GREEN     = 8'd40,
    parameter logic [7:0]  DMG_YELLOW    = 8'd20,
    parameter logic [7:0]  DMG_ORANGE    = 8'd10,
    parameter logic [7:0]  DMG_BLUE      = 8'd5,
    parameter int unsigned PLAYER_HP     = 300,
    parameter int unsigned MONSTER_HP    = 500,
    parameter int unsigned HIT_DMG       = 15,
    parameter int unsigned INV_FRAMES    = 30,
    parameter int unsigned FIGHT_FRAMES  = 120,
    parameter int unsigned RESULT_FRAMES = 60,
    parameter int unsigned ESCAPE_FRAMES = 300
) (
    input  wire logic          i_clk,
    input  wire logic          i_rst_n,
    battle_sequencer_if.slave  bus
);
    localparam logic [15:0] c_center      = 16'(CENTER_X);
    localparam logic [15:0] c_green       = 16'(GREEN_HALF);
    localparam logic [15:0] c_yellow      = 16'(YELLOW_HALF);
    localparam logic [15:0] c_orange      = 16'(ORANGE_HALF);
    localparam logic [15:0] c_blue        = 16'(BLUE_HALF);
    localparam logic [15:0] c_player_hp   = 16'(PLAYER_HP);
    localparam logic [15:0] c_monster_hp  = 16'(MONSTER_HP);
    localparam logic [15:0] c_hit_dmg     = 16'(HIT_DMG);
    localparam logic [7:0]  c_inv         = 8'(INV_FRAMES);
    localparam logic [15:0] c_fight_last  = 16'(FIGHT_FRAMES - 1);
    localparam logic [15:0] c_result_last = 16'(RESULT_FRAMES - 1);
    localparam logic [15:0] c_escape_last = 16'(ESCAPE_FRAMES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FIGHT  = 3'd1,
        S_RESULT = 3'd2,
        S_ESCAPE = 3'd3,
        S_OVER   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  inv_q, inv_d;
    logic [15:0] lat_q, lat_d;
    logic        miss_q, miss_d;
    logic        first_q, first_d;
    logic [15:0] php_q, php_d;
    logic [15:0] mhp_q, mhp_d;
    logic [7:0]  last_q, last_d;
    logic        win_q, win_d;
    logic        lose_q, lose_d;
    logic        bar_reset_q, bar_reset_d;

    logic        w_start;
    logic        w_restart;
    logic [15:0] w_dist;
    logic [7:0]  w_dmg;

    assign w_start   = bus.i_rx_receive && (bus.i_rx_data == 8'h20);
    assign w_restart = bus.i_rx_receive && (bus.i_rx_data == 8'h72);
    assign w_dist    = (lat_q >= c_center) ? (lat_q - c_center) : (c_center - lat_q);

    // Innermost zone first so that the narrowest matching window wins.
    always_comb begin
        w_dmg = 8'd0;
        if (!miss_q) begin
            if (w_dist <= c_green)       w_dmg = DMG_GREEN;
            else if (w_dist <= c_yellow) w_dmg = DMG_YELLOW;
            else if (w_dist <= c_orange) w_dmg = DMG_ORANGE;
            else if (w_dist <= c_blue)   w_dmg = DMG_BLUE;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        inv_d   = inv_q;
        lat_d   = lat_q;
        miss_d  = miss_q;
        first_d = 1'b0;
        php_d   = php_q;
        mhp_d   = mhp_q;
        last_d  = last_q;
        win_d   = win_q;
        lose_d  = lose_q;
        case (state_q)
            S_IDLE: begin
                if (w_start) begin
                    state_d = S_FIGHT;
                    cnt_d   = 16'd0;
                end
            end
            S_FIGHT: begin
                if (w_start) begin
                    lat_d   = bus.i_bar_x;
                    miss_d  = 1'b0;
                    first_d = 1'b1;
                    cnt_d   = 16'd0;
                    state_d = S_RESULT;
                end else if (bus.i_animate) begin
                    if (cnt_q == c_fight_last) begin
                        miss_d  = 1'b1;
                        first_d = 1'b1;
                        cnt_d   = 16'd0;
                        state_d = S_RESULT;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            S_RESULT: begin
                if (first_q) begin
                    last_d = w_dmg;
                    mhp_d  = (mhp_q > {8'd0, w_dmg}) ? (mhp_q - {8'd0, w_dmg}) : 16'd0;
                end
                if (bus.i_animate) begin
                    if (cnt_q == c_result_last) begin
                        cnt_d   = 16'd0;
                        inv_d   = 8'd0;
                        win_d   = (mhp_d == 16'd0);
                        state_d = (mhp_d == 16'd0) ? S_OVER : S_ESCAPE;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            S_ESCAPE: begin
                if (bus.i_animate) begin
                    if (bus.i_hit && (inv_q == 8'd0)) begin
                        php_d = (php_q > c_hit_dmg) ? (php_q - c_hit_dmg) : 16'd0;
                        inv_d = c_inv;
                    end else if (inv_q != 8'd0) begin
                        inv_d = inv_q - 8'd1;
                    end
                    // A lethal hit on the final tick still ends the game.
                    if (php_d == 16'd0) begin
                        lose_d  = 1'b1;
                        cnt_d   = 16'd0;
                        state_d = S_OVER;
                    end else if (cnt_q == c_escape_last) begin
                        cnt_d   = 16'd0;
                        state_d = S_FIGHT;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            S_OVER: begin
                if (w_restart) begin
                    state_d = S_IDLE;
                    cnt_d   = 16'd0;
                    inv_d   = 8'd0;
                    php_d   = c_player_hp;
                    mhp_d   = c_monster_hp;
                    last_d  = 8'd0;
                    win_d   = 1'b0;
                    lose_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        bar_reset_d = (state_d == S_FIGHT) && (state_q != S_FIGHT);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 16'd0;
            inv_q       <= 8'd0;
            lat_q       <= 16'd0;
            miss_q      <= 1'b0;
            first_q     <= 1'b0;
            php_q       <= c_player_hp;
            mhp_q       <= c_monster_hp;
            last_q      <= 8'd0;
            win_q       <= 1'b0;
            lose_q      <= 1'b0;
            bar_reset_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            inv_q       <= inv_d;
            lat_q       <= lat_d;
            miss_q      <= miss_d;
            first_q     <= first_d;
            php_q       <= php_d;
            mhp_q       <= mhp_d;
            last_q      <= last_d;
            win_q       <= win_d;
            lose_q      <= lose_d;
            bar_reset_q <= bar_reset_d;
        end
    end

    assign bus.o_phase      = state_q;
    assign bus.o_bar_run    = (state_q == S_FIGHT);
    assign bus.o_bar_reset  = bar_reset_q;
    assign bus.o_player_hp  = php_q;
    assign bus.o_monster_hp = mhp_q;
    assign bus.o_last_dmg   = last_q;
    assign bus.o_win        = win_q;
    assign bus.o_lose       = lose_q;

`ifdef BATTLE_TX_ECHO_EN
    logic       pend_q, pend_d;
    logic [7:0] byte_q, byte_d;
    logic       txs_q, txs_d;
    logic [7:0] txd_q, txd_d;

    // A fresh phase change replaces any byte still waiting for the transmitter.
    always_comb begin
        pend_d = pend_q;
        byte_d = byte_q;
        txs_d  = 1'b0;
        txd_d  = txd_q;
        if (state_d != state_q) begin
            pend_d = 1'b1;
            byte_d = 8'h30 + {5'd0, state_d};
        end else if (pend_q && bus.i_tx_idle) begin
            pend_d = 1'b0;
            txs_d  = 1'b1;
            txd_d  = byte_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pend_q <= 1'b0;
            byte_q <= 8'd0;
            txs_q  <= 1'b0;
            txd_q  <= 8'd0;
        end else begin
            pend_q <= pend_d;
            byte_q <= byte_d;
            txs_q  <= txs_d;
            txd_q  <= txd_d;
        end
    end

    assign bus.o_tx_transmit = txs_q;
    assign bus.o_tx_data     = txd_q;
`else
    logic w_unused;
    assign w_unused          = bus.i_tx_idle;
    assign bus.o_tx_transmit = 1'b0;
    assign bus.o_tx_data     = 8'd0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_battle_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_battle_sequencer : directed rounds against a second, low-HP instance
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_battle_sequencer;
`ifdef BATTLE_TX_ECHO_EN
    localparam int ECHO = 1;
`else
    localparam int ECHO = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    battle_sequencer_if b ();
    battle_sequencer_if b2 ();

    assign b2.i_animate    = b.i_animate;
    assign b2.i_rx_receive = b.i_rx_receive;
    assign b2.i_rx_data    = b.i_rx_data;
    assign b2.i_bar_x      = b.i_bar_x;
    assign b2.i_hit        = b.i_hit;
    assign b2.i_tx_idle    = b.i_tx_idle;

    battle_sequencer u_dut (.i_clk(clk), .i_rst_n(rst_n), .bus(b));
    battle_sequencer #(.PLAYER_HP(15)) u_low (.i_clk(clk), .i_rst_n(rst_n), .bus(b2));

    typedef struct {
        string tag;
        int    val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic sb_push(input string t, input int v);
        exp_t e;
        e.tag = t;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_empty observed %0d required a queued expectation", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === 32'(e.val)) else begin
                errors++;
                $error("FAIL %s observed %0d required %0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick();
        b.i_animate = 1'b1;
        cyc(1);
        b.i_animate = 1'b0;
        cyc(2);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic key(input logic [7:0] code, input logic [15:0] x);
        b.i_rx_receive = 1'b1;
        b.i_rx_data    = code;
        b.i_bar_x      = x;
        cyc(1);
        b.i_rx_receive = 1'b0;
    endtask

    // RESULT lasts 60 ticks, ESCAPE 300 ticks, then a new FIGHT with a bar reset.
    task automatic result_then_escape(input string r);
        sb_push({r, "_result_hold"}, 2);  ticks(59);  sb_check(32'(b.o_phase));
        sb_push({r, "_to_escape"}, 3);    ticks(1);   sb_check(32'(b.o_phase));
        sb_push({r, "_escape_hold"}, 3);  ticks(299); sb_check(32'(b.o_phase));
        b.i_animate = 1'b1;
        sb_push({r, "_to_fight"}, 1);
        sb_push({r, "_bar_reset"}, 1);
        cyc(1);
        sb_check(32'(b.o_phase));
        sb_check(32'(b.o_bar_reset));
        b.i_animate = 1'b0;
        sb_push({r, "_bar_reset_end"}, 0);
        cyc(1);
        sb_check(32'(b.o_bar_reset));
        cyc(1);
    endtask

    initial begin
        int strobes;
        b.i_animate    = 1'b0;
        b.i_rx_receive = 1'b0;
        b.i_rx_data    = 8'h00;
        b.i_bar_x      = 16'd0;
        b.i_hit        = 1'b0;
        b.i_tx_idle    = 1'b0;
        cyc(2);

        sb_push("rst_phase", 0);     sb_check(32'(b.o_phase));
        sb_push("rst_php", 300);     sb_check(32'(b.o_player_hp));
        sb_push("rst_mhp", 500);     sb_check(32'(b.o_monster_hp));
        sb_push("rst_dmg", 0);       sb_check(32'(b.o_last_dmg));
        sb_push("rst_winlose", 0);   sb_check(32'({b.o_win, b.o_lose}));
        sb_push("rst_bar", 0);       sb_check(32'({b.o_bar_run, b.o_bar_reset}));
        sb_push("rst_tx", 0);        sb_check(32'({b.o_tx_transmit, b.o_tx_data}));
        sb_push("rst_low_php", 15);  sb_check(32'(b2.o_player_hp));
        rst_n = 1'b1;
        cyc(1);

        sb_push("ignored_key", 0);
        key(8'h41, 16'd0);
        sb_check(32'(b.o_phase));

        // Round 1: near-perfect stop left of centre
        sb_push("r1_fight", 1);
        sb_push("r1_run_reset", 3);
        key(8'h20, 16'd0);
        sb_check(32'(b.o_phase));
        sb_check(32'({b.o_bar_run, b.o_bar_reset}));
        sb_push("r1_reset_pulse_end", 0);
        cyc(1);
        sb_check(32'(b.o_bar_reset));
        sb_push("r1_result", 2);
        key(8'h20, 16'd318);
        sb_check(32'(b.o_phase));
        sb_push("r1_dmg", 40);
        sb_push("r1_mhp", 460);
        cyc(1);
        sb_check(32'(b.o_last_dmg));
        sb_check(32'(b.o_monster_hp));
        result_then_escape("r1");

        // Round 2: d=220 is past the blue zone
        key(8'h20, 16'd100);
        sb_push("r2_dmg", 0);
        sb_push("r2_mhp", 460);
        cyc(1);
        sb_check(32'(b.o_last_dmg));
        sb_check(32'(b.o_monster_hp));
        result_then_escape("r2");

        // Round 3: d=100 sits exactly on the yellow edge
        key(8'h20, 16'd420);
        sb_push("r3_dmg", 20);
        sb_push("r3_mhp", 440);
        cyc(1);
        sb_check(32'(b.o_last_dmg));
        sb_check(32'(b.o_monster_hp));
        result_then_escape("r3");

        // Round 4: timeout counts as a miss even with the bar centred
        b.i_bar_x = 16'd320;
        sb_push("r4_fight_hold", 1);  ticks(119); sb_check(32'(b.o_phase));
        sb_push("r4_timeout", 2);     ticks(1);   sb_check(32'(b.o_phase));
        sb_push("r4_dmg", 0);         sb_check(32'(b.o_last_dmg));
        sb_push("r4_mhp", 440);       sb_check(32'(b.o_monster_hp));
        result_then_escape("r4");

        // Round 5: key on the timeout tick wins; d=170 scores blue
        ticks(119);
        b.i_animate = 1'b1;
        sb_push("r5_result", 2);
        key(8'h20, 16'd490);
        b.i_animate = 1'b0;
        sb_check(32'(b.o_phase));
        sb_push("r5_dmg", 5);
        sb_push("r5_mhp", 435);
        cyc(1);
        sb_check(32'(b.o_last_dmg));
        sb_check(32'(b.o_monster_hp));
        sb_push("r5_escape", 3);  ticks(60); sb_check(32'(b.o_phase));

        b.i_hit = 1'b1;
        sb_push("hit1_php", 285);
        sb_push("low_over", 4);
        sb_push("low_lose", 1);
        sb_push("low_win", 0);
        sb_push("low_php", 0);
        tick();
        sb_check(32'(b.o_player_hp));
        sb_check(32'(b2.o_phase));
        sb_check(32'(b2.o_lose));
        sb_check(32'(b2.o_win));
        sb_check(32'(b2.o_player_hp));
        sb_push("inv_two_hits", 270);
        sb_push("escape_still", 3);
        ticks(39);
        sb_check(32'(b.o_player_hp));
        sb_check(32'(b.o_phase));
        b.i_hit = 1'b0;

        sb_push("low_restart", 0);
        sb_push("low_reload", 15);
        sb_push("low_lose_clr", 0);
        sb_push("escape_ignores_r", 3);
        key(8'h72, 16'd0);
        sb_check(32'(b2.o_phase));
        sb_check(32'(b2.o_player_hp));
        sb_check(32'(b2.o_lose));
        sb_check(32'(b.o_phase));

        ticks(10);
        rst_n = 1'b0;
        sb_push("midrst_phase", 0);
        sb_push("midrst_php", 300);
        sb_push("midrst_mhp", 500);
        sb_push("midrst_dmg", 0);
        cyc(1);
        sb_check(32'(b.o_phase));
        sb_check(32'(b.o_player_hp));
        sb_check(32'(b.o_monster_hp));
        sb_check(32'(b.o_last_dmg));
        rst_n = 1'b1;
        cyc(1);

        // Two phase changes while the transmitter is busy, then release it
        key(8'h20, 16'd0);
        cyc(1);
        key(8'h20, 16'd0);
        cyc(1);
        b.i_tx_idle = 1'b1;
        strobes = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            if (b.o_tx_transmit === 1'b1) strobes++;
        end
        sb_push("echo_strobes", ECHO);
        sb_check(32'(strobes));
        sb_push("echo_data", (ECHO != 0) ? 32'h32 : 0);
        sb_check(32'(b.o_tx_data));

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_leftover observed %0d required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
